// File: rtl/rfaludm_ctrl_if.sv
// Purpose : bundles the rfaludm_ctrl request, instruction, flag and datapath-control signals.
// Latency : none, wires only.
// Backpressure: none here; the controller ignores start_i while busy_o is high.
// Ports (controller view, modport slave):
//   in : start_i, instr_i[31:0], zero_i
//   out: read1_o, read2_o, ins_15_11_o, sein_o, reg_dst_o, reg_write_o, alu_src_o,
//        mem_to_reg_o, mem_write_o, mem_read_o, alu_op_o[1:0], busy_o, done_o,
//        branch_taken_o, illegal_o
interface rfaludm_ctrl_if;
    logic        start_i;
    logic [31:0] instr_i;
    logic        zero_i;
    logic [4:0]  read1_o;
    logic [4:0]  read2_o;
    logic [4:0]  ins_15_11_o;
    logic [15:0] sein_o;
    logic        reg_dst_o;
    logic        reg_write_o;
    logic        alu_src_o;
    logic        mem_to_reg_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [1:0]  alu_op_o;
    logic        busy_o;
    logic        done_o;
    logic        branch_taken_o;
    logic        illegal_o;

    // Controller side.
    modport slave (
        input  start_i, instr_i, zero_i,
        output read1_o, read2_o, ins_15_11_o, sein_o,
               reg_dst_o, reg_write_o, alu_src_o, mem_to_reg_o,
               mem_write_o, mem_read_o, alu_op_o,
               busy_o, done_o, branch_taken_o, illegal_o
    );

    // Requester / datapath side.
    modport master (
        output start_i, instr_i, zero_i,
        input  read1_o, read2_o, ins_15_11_o, sein_o,
               reg_dst_o, reg_write_o, alu_src_o, mem_to_reg_o,
               mem_write_o, mem_read_o, alu_op_o,
               busy_o, done_o, branch_taken_o, illegal_o
    );
endinterface

// File: rtl/rfaludm_ctrl.sv
// Purpose : multi-cycle FSM sequencing the RFALUDM datapath one MIPS-subset instruction at a time.
// Latency : busy R=3, lw=4, sw=3, beq=2, illegal=1 cycles; done_o pulses in the first IDLE cycle after.
// Backpressure: start_i is accepted only in IDLE (including the done cycle), ignored otherwise.
// Ports: clk_i, rst_i (synchronous, active-high), bus (rfaludm_ctrl_if.slave).
module rfaludm_ctrl (
    input  logic          clk_i,
    input  logic          rst_i,
    rfaludm_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        bt_q, bt_d;

    logic [5:0]  opcode;
    logic        is_rtype, is_lw, is_sw, is_beq, is_legal;

    assign opcode   = ir_q[31:26];
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_legal = is_rtype | is_lw | is_sw | is_beq;

    // Next-state logic. done/illegal are registered so they appear in the
    // first IDLE cycle and never depend combinationally on inputs.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        bt_d      = bt_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    ir_d    = bus.instr_i;
                    state_d = S_DECODE;
                    // A new non-branch instruction invalidates the old branch result.
                    if (bus.instr_i[31:26] != OP_BEQ) begin
                        bt_d = 1'b0;
                    end
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_rtype) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    // beq resolves here from the ALU zero flag.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    bt_d    = bus.zero_i;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            bt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            bt_q      <= bt_d;
        end
    end

    // Moore control decode from (state, opcode) only.
    always_comb begin
        bus.reg_dst_o    = 1'b0;
        bus.reg_write_o  = 1'b0;
        bus.alu_src_o    = 1'b0;
        bus.mem_to_reg_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_read_o   = 1'b0;
        bus.alu_op_o     = ALU_ADD;
        case (state_q)
            S_EXEC: begin
                if (is_rtype) begin
                    bus.alu_op_o = ALU_FUNCT;
                end else if (is_lw || is_sw) begin
                    bus.alu_src_o = 1'b1;
                end else if (is_beq) begin
                    bus.alu_op_o = ALU_SUB;
                end
            end
            S_MEM: begin
                bus.alu_src_o = 1'b1;
                if (is_lw) begin
                    bus.mem_read_o = 1'b1;
                end else if (is_sw) begin
                    bus.mem_write_o = 1'b1;
                end
            end
            S_WB: begin
                bus.reg_write_o = 1'b1;
                if (is_rtype) begin
                    bus.reg_dst_o = 1'b1;
                    bus.alu_op_o  = ALU_FUNCT;
                end else if (is_lw) begin
                    bus.mem_to_reg_o = 1'b1;
                    bus.mem_read_o   = 1'b1;
                    bus.alu_src_o    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.read1_o        = ir_q[25:21];
    assign bus.read2_o        = ir_q[20:16];
    assign bus.ins_15_11_o    = ir_q[15:11];
    assign bus.sein_o         = ir_q[15:0];
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.done_o         = done_q;
    assign bus.illegal_o      = illegal_q;
    assign bus.branch_taken_o = bt_q;

endmodule

// File: tb/tb_rfaludm_ctrl.sv
// Purpose : self-checking bench for rfaludm_ctrl: vector table, hand sequences, random vs model.
// Latency : checks busy-cycle counts and done timing per instruction class.
// Backpressure: checks that start is ignored while busy and accepted in the done cycle.
module tb_rfaludm_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rfaludm_ctrl_if bus();

    rfaludm_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] alu_op;
    } ctl_t;

    // Observed behaviour of one instruction.
    typedef struct packed {
        int          busy;
        int          rw;
        int          mw;
        int          mr;
        int          active;
        logic        done_seen;
        logic        ill;
        logic        bt;
        logic        both;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [15:0] se;
    } res_t;

    // Expected behaviour of one instruction.
    typedef struct packed {
        int   busy;
        int   rw;
        int   mw;
        int   mr;
        int   active;
        logic ill;
        logic bt;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        zero;
        exp_t        e;
    } vec_t;

    ctl_t snap [8];

    // Reference: per-class totals from the instruction semantics. DECODE is
    // all-zero, every later busy cycle drives at least one control.
    function automatic exp_t model(input logic [31:0] instr, input logic zero);
        exp_t e;
        e = '0;
        case (instr[31:26])
            6'h00: begin e.busy = 3; e.rw = 1; end
            6'h23: begin e.busy = 4; e.rw = 1; e.mr = 2; end
            6'h2B: begin e.busy = 3; e.mw = 1; end
            6'h04: begin e.busy = 2; e.bt = zero; end
            default: begin e.busy = 1; e.ill = 1'b1; end
        endcase
        e.active = e.busy - 1;
        return e;
    endfunction

    // Called at a negedge with the FSM in IDLE; returns at the negedge of the done cycle.
    task automatic run(input logic [31:0] instr, input logic zero, output res_t r);
        ctl_t c;
        logic [31:0] rnd;
        r = '0;
        bus.start_i = 1'b1;
        bus.instr_i = instr;
        bus.zero_i  = zero;
        @(negedge clk);
        bus.start_i = 1'b0;
        rnd = $urandom;
        bus.instr_i = rnd;
        r.r1 = bus.read1_o;
        r.r2 = bus.read2_o;
        r.rd = bus.ins_15_11_o;
        r.se = bus.sein_o;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy_o) begin
                c = {bus.reg_dst_o, bus.reg_write_o, bus.alu_src_o, bus.mem_to_reg_o,
                     bus.mem_write_o, bus.mem_read_o, bus.alu_op_o};
                if (r.busy < 8) snap[r.busy] = c;
                r.busy++;
                if (c != '0) r.active++;
                if (bus.reg_write_o) r.rw++;
                if (bus.mem_write_o) r.mw++;
                if (bus.mem_read_o)  r.mr++;
                if (bus.mem_read_o && bus.mem_write_o) r.both = 1'b1;
                @(negedge clk);
            end else begin
                r.done_seen = bus.done_o;
                r.ill       = bus.illegal_o;
                r.bt        = bus.branch_taken_o;
                break;
            end
        end
    endtask

    task automatic compare(input string name, input logic [31:0] instr, input res_t r, input exp_t e);
        check({name, ".busy"},   32'(r.busy),   32'(e.busy));
        check({name, ".done"},   32'(r.done_seen), 32'd1);
        check({name, ".illegal"}, 32'(r.ill),   32'(e.ill));
        check({name, ".bt"},     32'(r.bt),     32'(e.bt));
        check({name, ".rw"},     32'(r.rw),     32'(e.rw));
        check({name, ".mw"},     32'(r.mw),     32'(e.mw));
        check({name, ".mr"},     32'(r.mr),     32'(e.mr));
        check({name, ".active"}, 32'(r.active), 32'(e.active));
        check({name, ".rdwr"},   32'(r.both),   32'd0);
        check({name, ".read1"},  32'(r.r1),     32'(instr[25:21]));
        check({name, ".read2"},  32'(r.r2),     32'(instr[20:16]));
        check({name, ".rd"},     32'(r.rd),     32'(instr[15:11]));
        check({name, ".sein"},   32'(r.se),     32'(instr[15:0]));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, ".busy"},  32'(bus.busy_o), 32'd0);
        check({name, ".done"},  32'(bus.done_o), 32'd0);
        check({name, ".ill"},   32'(bus.illegal_o), 32'd0);
        check({name, ".bt"},    32'(bus.branch_taken_o), 32'd0);
        check({name, ".ctl"},   32'({bus.reg_dst_o, bus.reg_write_o, bus.alu_src_o, bus.mem_to_reg_o,
                                     bus.mem_write_o, bus.mem_read_o, bus.alu_op_o}), 32'd0);
        check({name, ".fields"}, 32'({bus.read1_o, bus.read2_o, bus.ins_15_11_o, bus.sein_o}), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        exp_t e;
        logic [31:0] rnd;
        logic [5:0]  op;
        int  rw_cnt;
        int  done_cnt;

        //            instr          zero  busy rw mw mr act ill bt
        vecs[0] = '{32'h00221820, 1'b0, '{3, 1, 0, 0, 2, 1'b0, 1'b0}};
        vecs[1] = '{32'h8C040014, 1'b0, '{4, 1, 0, 2, 3, 1'b0, 1'b0}};
        vecs[2] = '{32'hAC050020, 1'b0, '{3, 0, 1, 0, 2, 1'b0, 1'b0}};
        vecs[3] = '{32'h10220008, 1'b1, '{2, 0, 0, 0, 1, 1'b0, 1'b1}};
        vecs[4] = '{32'h10220008, 1'b0, '{2, 0, 0, 0, 1, 1'b0, 1'b0}};
        vecs[5] = '{32'h10220008, 1'b1, '{2, 0, 0, 0, 1, 1'b0, 1'b1}};
        vecs[6] = '{32'hFC000000, 1'b1, '{1, 0, 0, 0, 0, 1'b1, 1'b0}};
        vecs[7] = '{32'h00A63022, 1'b0, '{3, 1, 0, 0, 2, 1'b0, 1'b0}};
        vecs[8] = '{32'h08000000, 1'b0, '{1, 0, 0, 0, 0, 1'b1, 1'b0}};

        bus.start_i = 1'b1;
        bus.instr_i = 32'hFFFF_FFFF;
        bus.zero_i  = 1'b1;
        rst = 1'b1;

        // Reset with start held high: reset wins.
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Vector table, run back-to-back (each start is issued in the done cycle).
        foreach (vecs[i]) begin
            run(vecs[i].instr, vecs[i].zero, r);
            compare($sformatf("vec%0d", i), vecs[i].instr, r, vecs[i].e);
        end

        // Per-state control values for each class.
        run(32'h00221820, 1'b0, r);
        check("add.decode_ctl", 32'(snap[0]), 32'd0);
        check("add.exec_aluop", 32'(snap[1].alu_op), 32'd2);
        check("add.exec_alusrc", 32'(snap[1].alu_src), 32'd0);
        check("add.wb_ctl", 32'({snap[2].reg_write, snap[2].reg_dst, snap[2].mem_to_reg}), 32'b110);
        run(32'h8C040014, 1'b0, r);
        check("lw.sein", 32'(r.se), 32'h14);
        check("lw.exec", 32'(snap[1]), 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}));
        check("lw.mem", 32'(snap[2]), 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0}));
        check("lw.wb", 32'(snap[3]), 32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0}));
        run(32'hAC050020, 1'b0, r);
        check("sw.mem", 32'(snap[2]), 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0}));
        run(32'h10220008, 1'b1, r);
        check("beq.exec_aluop", 32'(snap[1].alu_op), 32'd1);
        check("beq.bt", 32'(r.bt), 32'd1);

        // Done lasts one cycle and bt holds while idle.
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done_o), 32'd0);
        check("bt_held", 32'(bus.branch_taken_o), 32'd1);

        // Start pulsed during EXEC of an add is ignored.
        bus.start_i = 1'b1;
        bus.instr_i = 32'h00221820;
        @(negedge clk);                         // DECODE
        bus.start_i = 1'b0;
        @(negedge clk);                         // EXEC
        bus.start_i = 1'b1;
        bus.instr_i = 32'h8C040014;
        @(negedge clk);                         // WB
        bus.start_i = 1'b0;
        check("ign.read1", 32'(bus.read1_o), 32'd1);
        check("ign.read2", 32'(bus.read2_o), 32'd2);
        check("ign.wb_rw", 32'(bus.reg_write_o), 32'd1);
        @(negedge clk);
        check("ign.done", 32'(bus.done_o), 32'd1);
        check("ign.bt_cleared", 32'(bus.branch_taken_o), 32'd0);
        @(negedge clk);
        check("ign.idle", 32'(bus.busy_o), 32'd0);
        check("ign.ir_kept", 32'(bus.sein_o), 32'h1820);

        // Reset during MEM of lw.
        bus.start_i = 1'b1;
        bus.instr_i = 32'h8C040014;
        @(negedge clk);                         // DECODE
        bus.start_i = 1'b0;
        @(negedge clk);                         // EXEC
        @(negedge clk);                         // MEM
        check("rstmem.memread", 32'(bus.mem_read_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rstmem");
        rw_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.reg_write_o) rw_cnt++;
            if (bus.done_o) done_cnt++;
            @(negedge clk);
        end
        check("rstmem.no_rw", 32'(rw_cnt), 32'd0);
        check("rstmem.no_done", 32'(done_cnt), 32'd0);

        // Random instructions against the model.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: begin
                    op = 6'($urandom);
                    while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04)
                        op = 6'($urandom);
                end
            endcase
            rnd = $urandom;
            rnd = {op, rnd[25:0]};
            e = model(rnd, 1'($urandom));
            run(rnd, e.bt | (e.busy == 2 ? 1'b0 : 1'($urandom)), r);
            compare($sformatf("rnd%0d", n), rnd, r, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
